fx_addsub_pipe: RTL

Parametrised, pipelined fixed-point adder/subtractor. Successor to the combinational fixed-point adder.
- Independent Q-formats per operand and per result; per-operand signedness.
- Add/sub mode; valid/ready streaming with backpressure.
- Overflow and underflow flags; optional saturation.
- Sits in datapath pipelines between fixed-point producers and consumers.

---
 rtl/fx_addsub_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fx_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fx_addsub_pipe                                                           |
// | Three-stage fixed-point adder/subtractor (align, add/sub, format) with   |
// | valid/ready handshake, range flags and optional saturation selected by   |
// | the FX_ADDSUB_SAT_EN macro.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fx_addsub_pipe #(
  parameter int I1 = 2,
  parameter int F1 = 14,
  parameter int I2 = 2,
  parameter int F2 = 14,
  parameter int I3 = 2,
  parameter int F3 = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [I1+F1-1:0] a,
  input  logic             s1,
  input  logic [I2+F2-1:0] b,
  input  logic             s2,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [I3+F3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow
);

  localparam int c_W1 = I1 + F1;
  localparam int c_W2 = I2 + F2;
  localparam int c_W3 = I3 + F3;
  localparam int c_FI = (F1 > F2) ? F1 : F2;
  localparam int c_II = ((I1 > I2) ? I1 : I2) + 2;
  localparam int c_WI = c_II + c_FI;
  localparam int c_UP = (F3 > c_FI) ? (F3 - c_FI) : 0;
  localparam int c_DN = (c_FI > F3) ? (c_FI - F3) : 0;
  localparam int c_WC = c_WI + c_UP + c_W3 + 2;

  localparam logic signed [c_WC-1:0] c_SMAX = {{(c_WC-c_W3+1){1'b0}}, {(c_W3-1){1'b1}}};
  localparam logic signed [c_WC-1:0] c_SMIN = {{(c_WC-c_W3+1){1'b1}}, {(c_W3-1){1'b0}}};
  localparam logic signed [c_WC-1:0] c_UMAX = {{(c_WC-c_W3){1'b0}}, {c_W3{1'b1}}};

  logic                   w_adv;
  logic signed [c_WI-1:0] w_a_ext;
  logic signed [c_WI-1:0] w_b_ext;
  logic signed [c_WC-1:0] w_wide;
  logic signed [c_WC-1:0] w_val;
  logic                   w_ovf;
  logic                   w_udf;
  logic [c_W3-1:0]        w_c;

  logic                   r_v1;
  logic signed [c_WI-1:0] r_a1;
  logic signed [c_WI-1:0] r_b1;
  logic                   r_op1;
  logic                   r_rs1;
  logic                   r_v2;
  logic signed [c_WI-1:0] r_sum2;
  logic                   r_rs2;
  logic                   r_v3;
  logic [c_W3-1:0]        r_c;
  logic                   r_sign;
  logic                   r_ovf;
  logic                   r_udf;

  // One global enable: the whole pipe freezes while the output is held.
  assign w_adv    = !r_v3 | out_ready;
  assign in_ready = w_adv;

  assign w_a_ext = $signed({{(c_WI-c_W1){s1 & a[c_W1-1]}}, a}) <<< (c_FI - F1);
  assign w_b_ext = $signed({{(c_WI-c_W2){s2 & b[c_W2-1]}}, b}) <<< (c_FI - F2);

  // Only one of c_UP/c_DN is non-zero; >>> on a signed value floors toward -inf.
  assign w_wide = c_WC'(r_sum2);
  assign w_val  = (w_wide <<< c_UP) >>> c_DN;
  assign w_ovf  = r_rs2 ? (w_val > c_SMAX) : (w_val > c_UMAX);
  assign w_udf  = r_rs2 ? (w_val < c_SMIN) : w_val[c_WC-1];

  always_comb begin
    w_c = w_val[c_W3-1:0];
`ifdef FX_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_c = r_rs2 ? c_SMAX[c_W3-1:0] : c_UMAX[c_W3-1:0];
    end else if (w_udf) begin
      w_c = r_rs2 ? c_SMIN[c_W3-1:0] : '0;
    end
`else
    w_c = w_val[c_W3-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_op1  <= 1'b0;
      r_rs1  <= 1'b0;
      r_v2   <= 1'b0;
      r_sum2 <= '0;
      r_rs2  <= 1'b0;
      r_v3   <= 1'b0;
      r_c    <= '0;
      r_sign <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_a1   <= w_a_ext;
      r_b1   <= w_b_ext;
      r_op1  <= op;
      r_rs1  <= s1 | s2 | op;
      r_v2   <= r_v1;
      r_sum2 <= r_op1 ? (r_a1 - r_b1) : (r_a1 + r_b1);
      r_rs2  <= r_rs1;
      r_v3   <= r_v2;
      r_c    <= w_c;
      r_sign <= r_rs2;
      r_ovf  <= w_ovf;
      r_udf  <= w_udf;
    end
  end

  assign out_valid = r_v3;
  assign c         = r_c;
  assign sign      = r_sign;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule
`default_nettype wire
